// File: rtl/counter_int_pkg.sv
// Shared types and widths for the counter interrupt aggregation stage.
package counter_int_pkg;

    localparam int EVT_CNT_W  = 8;
    localparam int COAL_TMR_W = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        ASSERT = 2'd2
    } state_e;

endpackage

// File: rtl/counter_int_sync.sv
// Two-flop synchroniser for a vector of level sources, plus a third stage
// that flags the cycle in which each synchronised bit rises.
module counter_int_sync #(
    parameter int W = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_rise
);

    logic [W-1:0] s1_q, s2_q, s3_q;
    logic [W-1:0] s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = i_d;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign o_rise = s2_q & ~s3_q;

endmodule

// File: rtl/counter_int_ctrl.sv
// Aggregates per-counter interrupt sources into sticky status, a masked view,
// a first-pending index and a single coalesced CPU interrupt line.
module counter_int_ctrl
    import counter_int_pkg::*;
#(
    parameter int COUNTER_NUM = 4,
    parameter int IDX_W       = $clog2(COUNTER_NUM*8)
) (
    input  logic                     i_pclk,
    input  logic                     i_prst,
    input  logic [COUNTER_NUM*8-1:0] i_int_src,
    input  logic [COUNTER_NUM*8-1:0] i_int_en,
    input  logic [COUNTER_NUM*8-1:0] i_int_clr,
    input  logic [COUNTER_NUM*8-1:0] i_int_set,
    input  logic [7:0]               i_coal_thresh,
    input  logic [15:0]              i_coal_timeout,
    input  logic                     i_irq_ack,
    output logic [COUNTER_NUM*8-1:0] o_raw_status,
    output logic [COUNTER_NUM*8-1:0] o_status,
    output logic [COUNTER_NUM-1:0]   o_counter_summary,
    output logic                     o_first_valid,
    output logic [IDX_W-1:0]         o_first_idx,
    output logic [EVT_CNT_W-1:0]     o_event_cnt,
    output logic                     o_irq
);

    localparam int N = COUNTER_NUM * 8;

    logic [N-1:0]            rise;
    logic [N-1:0]            raw_q, raw_d;
    logic [EVT_CNT_W-1:0]    cnt_q, cnt_d;
    logic [COAL_TMR_W-1:0]   tmr_q, tmr_d;
    state_e                  state_q, state_d;
    logic                    irq_q, irq_d;
    logic                    status_any;
    logic                    new_evt;
    logic                    timed_out;

    counter_int_sync #(.W(N)) u_sync (
        .i_clk  (i_pclk),
        .i_rst  (i_prst),
        .i_d    (i_int_src),
        .o_rise (rise)
    );

    assign o_status   = raw_q & i_int_en;
    assign status_any = |o_status;

    always_comb begin
        o_counter_summary = '0;
        for (int c = 0; c < COUNTER_NUM; c++) begin
            o_counter_summary[c] = |o_status[c*8 +: 8];
        end
    end

    // Scan from the top so the lowest set bit is the last one written.
    always_comb begin
        o_first_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (o_status[k]) begin
                o_first_idx = IDX_W'(k);
            end
        end
    end

    always_comb begin
        // A new event in the same cycle as its clear survives.
        raw_d   = (raw_q & ~i_int_clr) | rise | i_int_set;
        new_evt = |(raw_d & ~raw_q & i_int_en);

        cnt_d = cnt_q;
        if (i_irq_ack) begin
            cnt_d = '0;
        end else if (new_evt && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end

        tmr_d = '0;
        if (state_q == ACCUM) begin
            tmr_d = (tmr_q == '1) ? tmr_q : tmr_q + 1'b1;
        end

        timed_out = (i_coal_timeout != 16'd0) && (tmr_q == i_coal_timeout - 16'd1);

        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (status_any) begin
                    state_d = (i_coal_thresh <= 8'd1) ? ASSERT : ACCUM;
                end
            end
            ACCUM: begin
                if (!status_any) begin
                    state_d = IDLE;
                end else if ((cnt_q >= i_coal_thresh) || timed_out) begin
                    state_d = ASSERT;
                end
            end
            ASSERT: begin
                if (i_irq_ack || !status_any) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        irq_d = (state_d == ASSERT);
    end

    always_ff @(posedge i_pclk) begin
        if (i_prst) begin
            raw_q   <= '0;
            cnt_q   <= '0;
            tmr_q   <= '0;
            state_q <= IDLE;
            irq_q   <= 1'b0;
        end else begin
            raw_q   <= raw_d;
            cnt_q   <= cnt_d;
            tmr_q   <= tmr_d;
            state_q <= state_d;
            irq_q   <= irq_d;
        end
    end

    assign o_raw_status  = raw_q;
    assign o_first_valid = status_any;
    assign o_event_cnt   = cnt_q;
    assign o_irq         = irq_q;

endmodule

// File: tb/tb_counter_int_ctrl.sv
// Scoreboard bench: each stimulus step queues the outputs it should cause at a
// given clock edge; a monitor compares them #1 after that edge.
module tb_counter_int_ctrl;

    localparam int CN = 4;
    localparam int N  = CN * 8;
    localparam int IW = $clog2(N);

    localparam int S_RAW = 0, S_STAT = 1, S_SUM = 2, S_FVLD = 3, S_FIDX = 4, S_CNT = 5, S_IRQ = 6;

    logic          clk;
    logic          i_prst;
    logic [N-1:0]  i_int_src, i_int_en, i_int_clr, i_int_set;
    logic [7:0]    i_coal_thresh;
    logic [15:0]   i_coal_timeout;
    logic          i_irq_ack;
    logic [N-1:0]  o_raw_status, o_status;
    logic [CN-1:0] o_counter_summary;
    logic          o_first_valid;
    logic [IW-1:0] o_first_idx;
    logic [7:0]    o_event_cnt;
    logic          o_irq;

    counter_int_ctrl #(.COUNTER_NUM(CN), .IDX_W(IW)) dut (
        .i_pclk            (clk),
        .i_prst            (i_prst),
        .i_int_src         (i_int_src),
        .i_int_en          (i_int_en),
        .i_int_clr         (i_int_clr),
        .i_int_set         (i_int_set),
        .i_coal_thresh     (i_coal_thresh),
        .i_coal_timeout    (i_coal_timeout),
        .i_irq_ack         (i_irq_ack),
        .o_raw_status      (o_raw_status),
        .o_status          (o_status),
        .o_counter_summary (o_counter_summary),
        .o_first_valid     (o_first_valid),
        .o_first_idx       (o_first_idx),
        .o_event_cnt       (o_event_cnt),
        .o_irq             (o_irq)
    );

    typedef struct {
        int          cyc;
        string       tag;
        int          sel;
        logic [31:0] val;
    } sb_t;

    sb_t sb[$];
    int  cyc   = 0;
    int  total = 0;
    int  bad   = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, act, want, cyc);
        end
    endtask

    function automatic logic [31:0] get(input int sel);
        case (sel)
            S_RAW:   return 32'(o_raw_status);
            S_STAT:  return 32'(o_status);
            S_SUM:   return 32'(o_counter_summary);
            S_FVLD:  return 32'(o_first_valid);
            S_FIDX:  return 32'(o_first_idx);
            S_CNT:   return 32'(o_event_cnt);
            S_IRQ:   return 32'(o_irq);
            default: return 32'hdead_beef;
        endcase
    endfunction

    task automatic exp_at(input int c, input string tag, input int sel, input logic [31:0] v);
        sb_t e;
        e.cyc = c;
        e.tag = tag;
        e.sel = sel;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic exp_zero(input int c, input string pfx);
        exp_at(c, {pfx, "_raw"},  S_RAW,  0);
        exp_at(c, {pfx, "_stat"}, S_STAT, 0);
        exp_at(c, {pfx, "_sum"},  S_SUM,  0);
        exp_at(c, {pfx, "_fvld"}, S_FVLD, 0);
        exp_at(c, {pfx, "_fidx"}, S_FIDX, 0);
        exp_at(c, {pfx, "_cnt"},  S_CNT,  0);
        exp_at(c, {pfx, "_irq"},  S_IRQ,  0);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Ack and clear everything in one cycle to return to a quiet IDLE.
    task automatic clean_all(input string pfx);
        int tk;
        tk = cyc;
        i_int_clr = '1;
        i_irq_ack = 1'b1;
        exp_at(tk + 1, {pfx, "_raw"}, S_RAW, 0);
        exp_at(tk + 1, {pfx, "_cnt"}, S_CNT, 0);
        exp_at(tk + 1, {pfx, "_irq"}, S_IRQ, 0);
        tick(1);
        i_int_clr = '0;
        i_irq_ack = 1'b0;
        tick(2);
    endtask

    always @(posedge clk) begin
        cyc++;
        #1;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                chk(sb[i].tag, get(sb[i].sel), sb[i].val);
                sb.delete(i);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, ta, tc, tx, ty, te, tm;
        i_prst         = 1'b1;
        i_int_src      = '0;
        i_int_en       = '0;
        i_int_clr      = '0;
        i_int_set      = '0;
        i_coal_thresh  = 8'd0;
        i_coal_timeout = 16'd0;
        i_irq_ack      = 1'b0;

        // Reset values
        tick(1);
        exp_zero(cyc + 1, "rst");
        tick(2);
        i_prst   = 1'b0;
        i_int_en = '1;
        tick(2);

        // Basic path: source bit 9 through the synchroniser
        t = cyc;
        i_int_src = 32'h0000_0200;
        exp_at(t + 2, "basic_raw_early", S_RAW,  0);
        exp_at(t + 3, "basic_raw",       S_RAW,  32'h200);
        exp_at(t + 3, "basic_stat",      S_STAT, 32'h200);
        exp_at(t + 3, "basic_sum",       S_SUM,  4'b0010);
        exp_at(t + 3, "basic_fvld",      S_FVLD, 1);
        exp_at(t + 3, "basic_fidx",      S_FIDX, 9);
        exp_at(t + 3, "basic_cnt",       S_CNT,  1);
        exp_at(t + 3, "basic_irq_early", S_IRQ,  0);
        exp_at(t + 4, "basic_irq",       S_IRQ,  1);
        tick(3);
        i_int_src = '0;
        tick(3);
        ta = cyc;
        i_irq_ack = 1'b1;
        exp_at(ta + 1, "ack_irq",   S_IRQ, 0);
        exp_at(ta + 1, "ack_cnt",   S_CNT, 0);
        exp_at(ta + 1, "ack_raw",   S_RAW, 32'h200);
        exp_at(ta + 2, "ack_reirq", S_IRQ, 1);
        tick(1);
        i_irq_ack = 1'b0;
        tick(1);
        tc = cyc;
        i_int_clr = 32'h200;
        exp_at(tc + 1, "clr9_raw",      S_RAW, 0);
        exp_at(tc + 1, "clr9_irq_hold", S_IRQ, 1);
        exp_at(tc + 2, "clr9_irq",      S_IRQ, 0);
        tick(1);
        i_int_clr = '0;
        tick(3);

        // Coalescing by event count
        i_coal_thresh = 8'd3;
        t = cyc;
        exp_at(t + 3, "coal_cnt2",  S_CNT,  2);
        exp_at(t + 3, "coal_irq2",  S_IRQ,  0);
        exp_at(t + 5, "coal_cnt3",  S_CNT,  3);
        exp_at(t + 5, "coal_irq3",  S_IRQ,  0);
        exp_at(t + 5, "coal_raw",   S_RAW,  32'h1021);
        exp_at(t + 5, "coal_sum",   S_SUM,  4'b0011);
        exp_at(t + 5, "coal_fidx",  S_FIDX, 0);
        exp_at(t + 5, "coal_fvld",  S_FVLD, 1);
        exp_at(t + 6, "coal_irq",   S_IRQ,  1);
        i_int_set = 32'h0000_0001;
        tick(1);
        i_int_set = '0;
        tick(1);
        i_int_set = 32'h0000_0020;
        tick(1);
        i_int_set = '0;
        tick(1);
        i_int_set = 32'h0000_1000;
        tick(1);
        i_int_set = '0;
        tick(3);
        clean_all("coal_clean");

        // Coalescing timeout
        i_coal_thresh  = 8'd10;
        i_coal_timeout = 16'd20;
        t = cyc;
        i_int_set = 32'h0000_0002;
        exp_at(t + 21, "tmo_irq_early", S_IRQ, 0);
        exp_at(t + 22, "tmo_irq",       S_IRQ, 1);
        exp_at(t + 22, "tmo_cnt",       S_CNT, 1);
        tick(1);
        i_int_set = '0;
        tick(23);
        clean_all("tmo_clean");
        i_coal_thresh  = 8'd0;
        i_coal_timeout = 16'd0;

        // Set/clear collision on bit 3
        t = cyc;
        i_int_set = 32'h0000_0008;
        exp_at(t + 2, "col_irq", S_IRQ, 1);
        tick(1);
        i_int_set = '0;
        tick(2);
        tx = cyc;
        i_int_set = 32'h0000_0008;
        i_int_clr = 32'h0000_0008;
        exp_at(tx + 1, "col_raw", S_RAW, 32'h8);
        exp_at(tx + 1, "col_cnt", S_CNT, 1);
        tick(1);
        i_int_set = '0;
        i_int_clr = '0;
        tick(1);
        ty = cyc;
        i_int_clr = 32'h0000_0008;
        exp_at(ty + 1, "clr3_raw",      S_RAW, 0);
        exp_at(ty + 1, "clr3_irq_hold", S_IRQ, 1);
        exp_at(ty + 2, "clr3_irq",      S_IRQ, 0);
        tick(1);
        i_int_clr = '0;
        tick(3);
        ta = cyc;
        i_irq_ack = 1'b1;
        exp_at(ta + 1, "col_ack_cnt", S_CNT, 0);
        tick(1);
        i_irq_ack = 1'b0;
        tick(1);

        // Mask: latched while disabled, no count on re-enable
        i_int_en = '0;
        t = cyc;
        i_int_src = 32'h0000_0080;
        exp_at(t + 3, "mask_raw",  S_RAW,  32'h80);
        exp_at(t + 3, "mask_stat", S_STAT, 0);
        exp_at(t + 4, "mask_irq",  S_IRQ,  0);
        exp_at(t + 4, "mask_cnt",  S_CNT,  0);
        exp_at(t + 4, "mask_fvld", S_FVLD, 0);
        tick(3);
        i_int_src = '0;
        tick(2);
        te = cyc;
        i_int_en = '1;
        exp_at(te + 1, "en_stat", S_STAT, 32'h80);
        exp_at(te + 1, "en_fidx", S_FIDX, 7);
        exp_at(te + 1, "en_irq",  S_IRQ,  1);
        exp_at(te + 2, "en_cnt",  S_CNT,  0);
        tick(3);
        tm = cyc;
        i_int_en = ~32'h0000_0080;
        exp_at(tm + 1, "unmask_stat", S_STAT, 0);
        exp_at(tm + 1, "unmask_irq",  S_IRQ,  0);
        exp_at(tm + 2, "reen_irq",    S_IRQ,  1);
        exp_at(tm + 2, "reen_cnt",    S_CNT,  0);
        tick(1);
        i_int_en = '1;
        tick(2);

        // Reset while asserted with five counted events
        t = cyc;
        exp_at(t + 5, "pre_rst_cnt", S_CNT, 5);
        exp_at(t + 5, "pre_rst_irq", S_IRQ, 1);
        for (int i = 0; i < 5; i++) begin
            i_int_set = 32'd1 << (20 + i);
            tick(1);
        end
        i_int_set = '0;
        i_prst = 1'b1;
        exp_zero(cyc + 1, "mid_rst");
        tick(1);
        i_prst = 1'b0;
        exp_at(cyc + 1, "post_rst_irq", S_IRQ, 0);
        tick(3);

        chk("sb_drain", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
